// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory.
// Signals: req_valid/ready/write, funct3, addr, wdata -> resp_valid, rdata, resp_err.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, funct3, addr, wdata,
    input  req_ready, resp_valid, rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata,
    output req_ready, resp_valid, rdata, resp_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32I data memory with fixed access latency.
// Ports: clk, rst (async, active-high), bus (slave side of data_memory_ctrl_if).
module data_memory_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nx;

  logic [3:0]  cnt;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [7:0]  mem [DEPTH];

  logic        accept;
  logic        commit;

  assign bus.req_ready  = (state != BUSY);
  assign bus.resp_valid = (state == RESP);
  assign bus.rdata      = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign commit = (state == BUSY) && (cnt == 4'd0);

  // Access checks on the captured request
  logic [2:0]            size_m1;
  logic [ADDR_WIDTH:0]   top;
  logic                  mis, oor, ill, err;

  always_comb begin
    size_m1 = 3'd3;
    unique case (f3_q[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      default: size_m1 = 3'd3;
    endcase
  end

  // Last byte touched; beyond all-ones means it ran off the top
  assign top = {1'b0, addr_q[ADDR_WIDTH-1:0]}
             + {{(ADDR_WIDTH-2){1'b0}}, size_m1};

  assign mis = ((f3_q[1:0] == 2'b01) && addr_q[0])
            || ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
  assign oor = ((addr_q >> ADDR_WIDTH) != 32'd0)
            || (top > {1'b0, {ADDR_WIDTH{1'b1}}});
  // Loads: 000,001,010,100,101; stores: 000,001,010
  assign ill = (f3_q[1:0] == 2'b11)
            || (f3_q[2] && (wr_q || f3_q[1]));
  assign err = mis || oor || ill;

  // Byte lanes, little-endian from addr upward
  logic [ADDR_WIDTH-1:0] ai [4];
  logic [7:0]            rb [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ai[i] = addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
      rb[i] = mem[ai[i]];
    end
  end

  logic [31:0] ld;

  always_comb begin
    ld = '0;
    unique case (f3_q)
      3'b000:  ld = {{24{rb[0][7]}}, rb[0]};
      3'b001:  ld = {{16{rb[1][7]}}, rb[1], rb[0]};
      3'b010:  ld = {rb[3], rb[2], rb[1], rb[0]};
      3'b100:  ld = {24'd0, rb[0]};
      3'b101:  ld = {16'd0, rb[1], rb[0]};
      default: ld = '0;
    endcase
  end

  logic [3:0] be;

  always_comb begin
    be = 4'b1111;
    unique case (f3_q[1:0])
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory is not reset; all lanes of a store land on the commit edge
  always_ff @(posedge clk) begin
    if (commit && wr_q && !err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ai[i]] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = accept ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        wr_q    <= bus.req_write;
        f3_q    <= bus.funct3;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rdata_q <= (wr_q || err) ? 32'd0 : ld;
        err_q   <= err;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: two instances (LATENCY 1 and 3)
// driven through one muxed request port and checked against a byte-array model.
module tb_data_memory_ctrl;
  logic        clk;
  logic        rst;
  int          sel;
  logic        rv, rw;
  logic [2:0]  f3;
  logic [31:0] a, wd;

  logic        rdy, rvo, erro;
  logic [31:0] rdo;

  int  n_chk  = 0;
  int  n_fail = 0;
  time t_acc;

  logic [7:0] mdl [2][4096];

  data_memory_ctrl_if bus1();
  data_memory_ctrl_if bus3();

  assign bus1.req_valid = rv && (sel == 1);
  assign bus1.req_write = rw;
  assign bus1.funct3    = f3;
  assign bus1.addr      = a;
  assign bus1.wdata     = wd;

  assign bus3.req_valid = rv && (sel == 3);
  assign bus3.req_write = rw;
  assign bus3.funct3    = f3;
  assign bus3.addr      = a;
  assign bus3.wdata     = wd;

  assign rdy  = (sel == 1) ? bus1.req_ready  : bus3.req_ready;
  assign rvo  = (sel == 1) ? bus1.resp_valid : bus3.resp_valid;
  assign rdo  = (sel == 1) ? bus1.rdata      : bus3.rdata;
  assign erro = (sel == 1) ? bus1.resp_err   : bus3.resp_err;

  data_memory_ctrl #(.ADDR_WIDTH(12), .LATENCY(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  data_memory_ctrl #(.ADDR_WIDTH(12), .LATENCY(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain byte array, rules straight from the ISA semantics
  task automatic model(input bit w, input logic [2:0] f,
                       input logic [31:0] ad, input logic [31:0] wv,
                       output logic [31:0] er, output bit ee);
    int m, sz;
    logic [31:0] v;
    logic [63:0] last;
    m  = (sel == 1) ? 0 : 1;
    sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    ee = 1'b0;
    er = 32'd0;
    if (w && !(f inside {3'd0, 3'd1, 3'd2})) ee = 1'b1;
    if (!w && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ee = 1'b1;
    if ((ad % sz) != 0) ee = 1'b1;
    last = {32'd0, ad} + 64'(sz);
    if (last > 64'd4096) ee = 1'b1;
    if (ee) return;
    if (w) begin
      for (int i = 0; i < sz; i++) mdl[m][ad[11:0] + 12'(i)] = wv[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < sz; i++)
        v = v | (32'(mdl[m][ad[11:0] + 12'(i)]) << (8 * i));
      if (f == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      er = v;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One access; returns in the response cycle with rv low
  task automatic xact(input string tag, input bit w, input logic [2:0] f,
                      input logic [31:0] ad, input logic [31:0] wv,
                      output logic [31:0] gd, output logic ge);
    logic [31:0] er;
    bit ee, acc;
    int n, lo;
    rv = 1'b1; rw = w; f3 = f; a = ad; wd = wv;
    n = 0; acc = 1'b0; gd = 32'd0; ge = 1'b0;
    while (!acc && n < 50) begin
      acc = rdy;
      @(posedge clk);
      #1;
      n++;
    end
    rv = 1'b0;
    t_acc = $time;
    check({tag, ".acc"}, 32'(acc), 32'd1);
    if (!acc) return;
    n = 0; lo = 0;
    do begin
      if (!rdy) lo++;
      @(posedge clk);
      #1;
      n++;
    end while (!rvo && n < 40);
    check({tag, ".lat"}, 32'(n), 32'(sel));
    check({tag, ".rdy_lo"}, 32'(lo), 32'(sel));
    gd = rdo;
    ge = erro;
    model(w, f, ad, wv, er, ee);
    check({tag, ".err"}, 32'(ge), 32'(ee));
    check({tag, ".rdata"}, gd, er);
  endtask

  logic [31:0] gd;
  logic        ge;
  time         t0;

  initial begin
    rst = 1'b1; sel = 1; rv = 1'b0; rw = 1'b0;
    f3 = 3'd0; a = 32'd0; wd = 32'd0;
    #2;
    check("rst.ready", 32'(rdy), 32'd1);
    check("rst.rvalid", 32'(rvo), 32'd0);
    check("rst.rdata", rdo, 32'd0);
    check("rst.err", 32'(erro), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Word store, readback, byte view
    xact("t1.sw", 1, 3'b010, 32'h100, 32'hDEAD_BEEF, gd, ge);
    check("t1.sw.err", 32'(ge), 32'd0);
    idle(1);
    check("t1.pulse", 32'(rvo), 32'd0);
    xact("t1.lw", 0, 3'b010, 32'h100, 32'd0, gd, ge);
    check("t1.lw.val", gd, 32'hDEAD_BEEF);
    xact("t1.lbu", 0, 3'b100, 32'h103, 32'd0, gd, ge);
    check("t1.lbu.val", gd, 32'h0000_00DE);

    // Sign/zero extension
    xact("t2.sb", 1, 3'b000, 32'h200, 32'h80, gd, ge);
    xact("t2.lb", 0, 3'b000, 32'h200, 32'd0, gd, ge);
    check("t2.lb.val", gd, 32'hFFFF_FF80);
    xact("t2.lbu", 0, 3'b100, 32'h200, 32'd0, gd, ge);
    check("t2.lbu.val", gd, 32'h0000_0080);
    xact("t2.sh", 1, 3'b001, 32'h202, 32'h8001, gd, ge);
    xact("t2.lh", 0, 3'b001, 32'h202, 32'd0, gd, ge);
    check("t2.lh.val", gd, 32'hFFFF_8001);
    xact("t2.lhu", 0, 3'b101, 32'h202, 32'd0, gd, ge);
    check("t2.lhu.val", gd, 32'h0000_8001);

    // Error cases leave memory untouched
    xact("t4.sw_mis", 1, 3'b010, 32'h102, 32'h1111_1111, gd, ge);
    check("t4.sw_mis.e", 32'(ge), 32'd1);
    xact("t4.lh_mis", 0, 3'b001, 32'h101, 32'd0, gd, ge);
    check("t4.lh_mis.e", 32'(ge), 32'd1);
    xact("t4.lw_oor", 0, 3'b010, 32'h1000, 32'd0, gd, ge);
    check("t4.lw_oor.e", 32'(ge), 32'd1);
    xact("t4.s011", 1, 3'b011, 32'h100, 32'h2222_2222, gd, ge);
    check("t4.s011.e", 32'(ge), 32'd1);
    xact("t4.lw", 0, 3'b010, 32'h100, 32'd0, gd, ge);
    check("t4.lw.val", gd, 32'hDEAD_BEEF);

    // Read-after-write in the RESP cycle
    xact("t6.sw", 1, 3'b010, 32'h400, 32'hCAFE_F00D, gd, ge);
    xact("t6.lw", 0, 3'b010, 32'h400, 32'd0, gd, ge);
    check("t6.lw.val", gd, 32'hCAFE_F00D);

    // Longer latency, back-to-back spacing
    idle(1);
    sel = 3;
    xact("t3.sw", 1, 3'b010, 32'h100, 32'h0BAD_F00D, gd, ge);
    t0 = t_acc;
    xact("t3.lw", 0, 3'b010, 32'h100, 32'd0, gd, ge);
    check("t3.space", 32'((t_acc - t0) / 10), 32'd4);
    check("t3.lw.val", gd, 32'h0BAD_F00D);

    // Reset during BUSY aborts a store
    xact("t5.pre", 1, 3'b010, 32'h300, 32'hA5A5_5A5A, gd, ge);
    xact("t5.ld", 0, 3'b010, 32'h300, 32'd0, gd, ge);
    idle(1);
    rv = 1'b1; rw = 1'b1; f3 = 3'b010; a = 32'h300; wd = 32'h1234_5678;
    @(posedge clk);
    #1;
    rv = 1'b0;
    idle(1);
    check("t5.busy", 32'(rdy), 32'd0);
    rst = 1'b1;
    #1;
    check("t5.ready", 32'(rdy), 32'd1);
    check("t5.rvalid", 32'(rvo), 32'd0);
    check("t5.rdata", rdo, 32'd0);
    check("t5.err", 32'(erro), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    xact("t5.lw", 0, 3'b010, 32'h300, 32'd0, gd, ge);
    check("t5.lw.val", gd, 32'hA5A5_5A5A);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      sel = (d == 0) ? 1 : 3;
      idle(1);
      for (int k = 0; k < 16; k++)
        xact("rnd.init", 1, 3'b010, 32'h500 + 32'(4 * k), $urandom, gd, ge);
      xact("rnd.top", 1, 3'b010, 32'hFFC, $urandom, gd, ge);
      for (int k = 0; k < 80; k++) begin
        logic [31:0] ad;
        int c;
        c = $urandom_range(0, 9);
        if (c == 0)      ad = 32'h1000 + 32'($urandom_range(0, 255));
        else if (c == 1) ad = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else if (c == 2) ad = 32'hFFC + 32'($urandom_range(0, 3));
        else             ad = 32'h500 + 32'($urandom_range(0, 63));
        xact("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ad, $urandom, gd, ge);
        idle($urandom_range(0, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
